// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - streaming twiddle-factor generator for the radix-2 DIF FFT
// Quarter-wave cosine table, two synchronous read ports, quadrant folding and exact specials.
module twiddle_gen #(
    parameter  int N_FFT    = 256,
    parameter  int TW_WIDTH = 8,
    localparam int LOG2N    = $clog2(N_FFT),
    localparam int D        = N_FFT / 4,
    localparam int OUT_W    = TW_WIDTH + 2,
    localparam int STW      = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [STW-1:0]   stage,
    output logic             busy,
    output logic             tw_valid,
    input  logic             tw_ready,
    output logic [OUT_W-1:0] tw_re,
    output logic [OUT_W-1:0] tw_im,
    output logic [LOG2N-1:0] tw_idx,
    output logic             tw_last
);

    localparam int AW = LOG2N - 2;

    localparam logic [1:0] SPC_NONE = 2'd0;
    localparam logic [1:0] SPC_POS  = 2'd1;
    localparam logic [1:0] SPC_NEG  = 2'd2;
    localparam logic [1:0] SPC_ZERO = 2'd3;

    localparam logic [OUT_W-1:0] ONE = OUT_W'(1) << TW_WIDTH;

    // Table entry x = min(round(cos(2*pi*x/N) * 2^W), 2^W - 1), evaluated at elaboration.
    function automatic logic [TW_WIDTH-1:0] cos_entry(input int x);
        real th;
        real term;
        real c;
        int  v;
        th   = 6.283185307179586 * real'(x) / real'(N_FFT);
        term = 1.0;
        c    = 1.0;
        for (int n = 1; n <= 12; n++) begin
            term = -term * th * th / real'((2 * n - 1) * (2 * n));
            c    = c + term;
        end
        v = $rtoi(c * real'(2 ** TW_WIDTH) + 0.5);
        if (v > 2 ** TW_WIDTH - 1) begin
            v = 2 ** TW_WIDTH - 1;
        end
        return TW_WIDTH'(v);
    endfunction

    logic [TW_WIDTH-1:0] w_rom [D];

    for (genvar x = 0; x < D; x++) begin : g_rom
        localparam logic [TW_WIDTH-1:0] C_VAL = cos_entry(x);
        assign w_rom[x] = C_VAL;
    end

    // Returns {special[1:0], negate, rom_addr[AW-1:0]} for angle index a.
    function automatic logic [AW+2:0] fold(input logic [LOG2N-1:0] a);
        logic [1:0]    q;
        logic [AW-1:0] r;
        logic [AW-1:0] addr;
        logic [1:0]    spc;
        q    = a[LOG2N-1 -: 2];
        r    = a[AW-1:0];
        addr = q[0] ? -r : r;
        if (r != '0) begin
            spc = SPC_NONE;
        end else if (q == 2'd0) begin
            spc = SPC_POS;
        end else if (q == 2'd2) begin
            spc = SPC_NEG;
        end else begin
            spc = SPC_ZERO;
        end
        return {spc, q[1] ^ q[0], addr};
    endfunction

    function automatic logic [OUT_W-1:0] resolve(input logic [1:0] spc, input logic neg,
                                                 input logic [TW_WIDTH-1:0] t);
        logic [OUT_W-1:0] v;
        v = {2'b00, t};
        if (neg) begin
            v = -v;
        end
        case (spc)
            SPC_POS:  v = ONE;
            SPC_NEG:  v = -ONE;
            SPC_ZERO: v = '0;
            default:  ;
        endcase
        return v;
    endfunction

    logic             r_busy;
    logic             r_iss;
    logic [STW-1:0]   r_s;
    logic [LOG2N-1:0] r_j;

    logic             r_p1_v;
    logic             r_p1_last;
    logic             r_p1_neg_re;
    logic             r_p1_neg_im;
    logic [1:0]       r_p1_spc_re;
    logic [1:0]       r_p1_spc_im;
    logic [LOG2N-1:0] r_p1_idx;
    logic [TW_WIDTH-1:0] r_rom_re;
    logic [TW_WIDTH-1:0] r_rom_im;

    logic             r_tw_valid;
    logic             r_tw_last;
    logic [OUT_W-1:0] r_tw_re;
    logic [OUT_W-1:0] r_tw_im;
    logic [LOG2N-1:0] r_tw_idx;

    logic             w_en;
    logic             w_start_ok;
    logic             w_iss_v;
    logic             w_iss_last;
    logic             w_fire;
    logic             w_done;
    logic [STW-1:0]   w_iss_s;
    logic [LOG2N-1:0] w_iss_j;
    logic [LOG2N-1:0] w_span_m1;
    logic [LOG2N-1:0] w_k;
    logic [LOG2N-1:0] w_k_im;
    logic [AW+2:0]    w_fold_re;
    logic [AW+2:0]    w_fold_im;

    assign w_en       = !r_tw_valid || tw_ready;
    assign w_start_ok = start && !r_busy && (int'(stage) < LOG2N);

    // The accept cycle issues j=0 directly from the port so the first output lands two cycles later.
    assign w_iss_v    = w_start_ok || r_iss;
    assign w_iss_s    = r_iss ? r_s : stage;
    assign w_iss_j    = r_iss ? r_j : '0;
    assign w_span_m1  = LOG2N'((N_FFT >> (int'(w_iss_s) + 1)) - 1);
    assign w_iss_last = (w_iss_j == w_span_m1);
    assign w_fire     = w_iss_v && w_en;
    assign w_done     = r_tw_valid && tw_ready && r_tw_last;

    assign w_k        = w_iss_j << w_iss_s;
    assign w_k_im     = w_k + LOG2N'(D);
    assign w_fold_re  = fold(w_k);
    assign w_fold_im  = fold(w_k_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_iss  <= 1'b0;
            r_s    <= '0;
            r_j    <= '0;
        end else begin
            if (w_start_ok) begin
                r_busy <= 1'b1;
                r_s    <= stage;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end
            if (w_fire) begin
                r_j   <= w_iss_j + 1'b1;
                r_iss <= !w_iss_last;
            end else if (w_start_ok) begin
                r_j   <= '0;
                r_iss <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_v      <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p1_neg_re <= 1'b0;
            r_p1_neg_im <= 1'b0;
            r_p1_spc_re <= SPC_NONE;
            r_p1_spc_im <= SPC_NONE;
            r_p1_idx    <= '0;
            r_rom_re    <= '0;
            r_rom_im    <= '0;
        end else if (w_en) begin
            r_p1_v <= w_iss_v;
            if (w_iss_v) begin
                r_p1_last   <= w_iss_last;
                r_p1_idx    <= w_k;
                r_p1_spc_re <= w_fold_re[AW+2:AW+1];
                r_p1_spc_im <= w_fold_im[AW+2:AW+1];
                r_p1_neg_re <= w_fold_re[AW];
                r_p1_neg_im <= w_fold_im[AW];
                r_rom_re    <= w_rom[w_fold_re[AW-1:0]];
                r_rom_im    <= w_rom[w_fold_im[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tw_valid <= 1'b0;
            r_tw_last  <= 1'b0;
            r_tw_re    <= '0;
            r_tw_im    <= '0;
            r_tw_idx   <= '0;
        end else if (w_en) begin
            r_tw_valid <= r_p1_v;
            r_tw_last  <= r_p1_v && r_p1_last;
            if (r_p1_v) begin
                r_tw_re  <= resolve(r_p1_spc_re, r_p1_neg_re, r_rom_re);
                r_tw_im  <= resolve(r_p1_spc_im, r_p1_neg_im, r_rom_im);
                r_tw_idx <= r_p1_idx;
            end
        end
    end

    assign busy     = r_busy;
    assign tw_valid = r_tw_valid;
    assign tw_last  = r_tw_last;
    assign tw_re    = r_tw_re;
    assign tw_im    = r_tw_im;
    assign tw_idx   = r_tw_idx;

endmodule
